sparc_exu_regwpipe: RTL and testbench

//  - Write pipeline feeding the per-thread register (sparc_exu_reg).
//  - Stages a per-thread register update E->M->W, applies M/W kills, and

---
 rtl/sparc_exu_regwpipe.sv | 83 ++++++++
 tb/tb_sparc_exu_regwpipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sparc_exu_regwpipe.sv
// E->M->W write pipeline for the per-thread register, with M/W kills and an M>W>RF read bypass.
// Optional parity (EXU_REGW_PAR_EN) stages even parity of data_e and flags par_err_w on mismatch.
module sparc_exu_regwpipe #(
  parameter int SIZE = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            se,
  input  logic            wen_e,
  input  logic [3:0]      thr_e,
  input  logic [SIZE-1:0] data_e,
  input  logic            kill_m,
  input  logic            kill_w,
  input  logic [3:0]      thr_rd,
  input  logic [SIZE-1:0] data_rf,
  output logic            wen_w,
  output logic [3:0]      thr_w,
  output logic [SIZE-1:0] data_in_w,
  output logic [SIZE-1:0] data_rd,
`ifdef EXU_REGW_PAR_EN
  output logic            par_err_w,
`endif
  output logic            byp_hit
);

  logic            valid_m, valid_w;
  logic [3:0]      thr_m, thr_w_q;
  logic [SIZE-1:0] data_m, data_w;
  logic            thr_e_onehot;
  logic            hit_m, hit_w;

  assign thr_e_onehot = (thr_e != 4'b0) && ((thr_e & (thr_e - 4'd1)) == 4'b0);

`ifdef EXU_REGW_PAR_EN
  logic par_m, par_w;
`endif

  // Scan shifting (se=1) holds the functional state.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m <= 1'b0;
      valid_w <= 1'b0;
      thr_m   <= 4'b0;
      thr_w_q <= 4'b0;
      data_m  <= '0;
      data_w  <= '0;
`ifdef EXU_REGW_PAR_EN
      par_m   <= 1'b0;
      par_w   <= 1'b0;
`endif
    end else if (!se) begin
      valid_m <= wen_e & thr_e_onehot;
      thr_m   <= thr_e;
      data_m  <= data_e;
      valid_w <= valid_m & ~kill_m;
      thr_w_q <= thr_m;
      data_w  <= data_m;
`ifdef EXU_REGW_PAR_EN
      par_m   <= ^data_e;
      par_w   <= par_m;
`endif
    end
  end

  assign wen_w     = valid_w & ~kill_w;
  assign thr_w     = thr_w_q;
  assign data_in_w = data_w;

  assign hit_m   = valid_m & ~kill_m & (|(thr_m & thr_rd));
  assign hit_w   = valid_w & ~kill_w & (|(thr_w_q & thr_rd));
  assign byp_hit = hit_m | hit_w;

  always_comb begin
    data_rd = data_rf;
    if (hit_m)      data_rd = data_m;
    else if (hit_w) data_rd = data_w;
  end

`ifdef EXU_REGW_PAR_EN
  assign par_err_w = wen_w & ((^data_in_w) != par_w);
`endif

endmodule

// File: tb/tb_sparc_exu_regwpipe.sv
// Directed bench for sparc_exu_regwpipe: reset, latency, kills, bypass priority, bad thread selects.
module tb_sparc_exu_regwpipe;
  logic       clk = 1'b0;
  logic       reset, se, wen_e, kill_m, kill_w;
  logic [3:0] thr_e, thr_rd, thr_w;
  logic [2:0] data_e, data_rf, data_in_w, data_rd;
  logic       wen_w, byp_hit;
`ifdef EXU_REGW_PAR_EN
  logic       par_err_w;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sparc_exu_regwpipe #(.SIZE(3)) dut (
    .clk(clk), .reset(reset), .se(se), .wen_e(wen_e), .thr_e(thr_e), .data_e(data_e),
    .kill_m(kill_m), .kill_w(kill_w), .thr_rd(thr_rd), .data_rf(data_rf),
    .wen_w(wen_w), .thr_w(thr_w), .data_in_w(data_in_w), .data_rd(data_rd),
`ifdef EXU_REGW_PAR_EN
    .par_err_w(par_err_w),
`endif
    .byp_hit(byp_hit)
  );

  // Advance to the next cycle; inputs are driven 1ns after the edge, outputs read at negedge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    wen_e = 0; thr_e = 0; data_e = 0; kill_m = 0; kill_w = 0;
  endtask

  task automatic test_reset();
    reset = 1; se = 0; idle_inputs(); thr_rd = 4'b0000; data_rf = 3'h5;
    next_cycle(); next_cycle();
    reset = 0;
    next_cycle(); @(negedge clk);
    checks++; if (wen_w !== 1'b0)     begin failures++; $display("FAIL reset_wen_w got=%b exp=0", wen_w); end
    checks++; if (thr_w !== 4'b0)     begin failures++; $display("FAIL reset_thr_w got=%b exp=0000", thr_w); end
    checks++; if (data_in_w !== 3'h0) begin failures++; $display("FAIL reset_data_in_w got=%h exp=0", data_in_w); end
    checks++; if (byp_hit !== 1'b0)   begin failures++; $display("FAIL reset_byp_hit got=%b exp=0", byp_hit); end
    checks++; if (data_rd !== 3'h5)   begin failures++; $display("FAIL reset_data_rd got=%h exp=5", data_rd); end
  endtask

  task automatic test_basic_write();
    next_cycle();
    wen_e = 1; thr_e = 4'b0100; data_e = 3'h6; thr_rd = 4'b0100; data_rf = 3'h3;
    @(negedge clk);
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL basic_n_byp got=%b exp=0", byp_hit); end
    next_cycle(); idle_inputs(); @(negedge clk);
    checks++; if (data_rd !== 3'h6) begin failures++; $display("FAIL basic_n1_data_rd got=%h exp=6", data_rd); end
    checks++; if (byp_hit !== 1'b1) begin failures++; $display("FAIL basic_n1_byp got=%b exp=1", byp_hit); end
    checks++; if (wen_w !== 1'b0)   begin failures++; $display("FAIL basic_n1_wen_w got=%b exp=0", wen_w); end
    next_cycle(); @(negedge clk);
    checks++; if (wen_w !== 1'b1)      begin failures++; $display("FAIL basic_n2_wen_w got=%b exp=1", wen_w); end
    checks++; if (thr_w !== 4'b0100)   begin failures++; $display("FAIL basic_n2_thr_w got=%b exp=0100", thr_w); end
    checks++; if (data_in_w !== 3'h6)  begin failures++; $display("FAIL basic_n2_data_in_w got=%h exp=6", data_in_w); end
    checks++; if (data_rd !== 3'h6)    begin failures++; $display("FAIL basic_n2_data_rd got=%h exp=6", data_rd); end
    thr_rd = 4'b1000; #1;
    checks++; if (data_rd !== 3'h3)    begin failures++; $display("FAIL basic_other_thr_rd got=%h exp=3", data_rd); end
    thr_rd = 4'b0100;
    next_cycle(); @(negedge clk);
    checks++; if (wen_w !== 1'b0)   begin failures++; $display("FAIL basic_n3_wen_w got=%b exp=0", wen_w); end
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL basic_n3_byp got=%b exp=0", byp_hit); end
    checks++; if (data_rd !== 3'h3) begin failures++; $display("FAIL basic_n3_data_rd got=%h exp=3", data_rd); end
  endtask

  task automatic test_kill();
    // kill_m in n+1
    next_cycle();
    wen_e = 1; thr_e = 4'b0100; data_e = 3'h6; thr_rd = 4'b0100; data_rf = 3'h1;
    next_cycle(); idle_inputs(); kill_m = 1; @(negedge clk);
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL killm_n1_byp got=%b exp=0", byp_hit); end
    checks++; if (data_rd !== 3'h1) begin failures++; $display("FAIL killm_n1_data_rd got=%h exp=1", data_rd); end
    next_cycle(); kill_m = 0; @(negedge clk);
    checks++; if (wen_w !== 1'b0)   begin failures++; $display("FAIL killm_n2_wen_w got=%b exp=0", wen_w); end
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL killm_n2_byp got=%b exp=0", byp_hit); end
    // kill_w in n+2
    next_cycle();
    wen_e = 1; thr_e = 4'b0100; data_e = 3'h6;
    next_cycle(); idle_inputs();
    next_cycle(); kill_w = 1; @(negedge clk);
    checks++; if (wen_w !== 1'b0)   begin failures++; $display("FAIL killw_n2_wen_w got=%b exp=0", wen_w); end
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL killw_n2_byp got=%b exp=0", byp_hit); end
    // both kills in one cycle squash M and W
    next_cycle(); idle_inputs();
    wen_e = 1; thr_e = 4'b0001; data_e = 3'h2;
    next_cycle(); data_e = 3'h4;
    next_cycle(); idle_inputs(); kill_m = 1; kill_w = 1; @(negedge clk);
    checks++; if (wen_w !== 1'b0) begin failures++; $display("FAIL killboth_n2_wen_w got=%b exp=0", wen_w); end
    next_cycle(); idle_inputs(); @(negedge clk);
    checks++; if (wen_w !== 1'b0) begin failures++; $display("FAIL killboth_n3_wen_w got=%b exp=0", wen_w); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    wen_e = 1; thr_e = 4'b0010; data_e = 3'h1; thr_rd = 4'b0010; data_rf = 3'h7;
    next_cycle(); data_e = 3'h2;
    next_cycle(); idle_inputs(); @(negedge clk);
    checks++; if (data_rd !== 3'h2)   begin failures++; $display("FAIL b2b_n2_data_rd got=%h exp=2", data_rd); end
    checks++; if (wen_w !== 1'b1)     begin failures++; $display("FAIL b2b_n2_wen_w got=%b exp=1", wen_w); end
    checks++; if (data_in_w !== 3'h1) begin failures++; $display("FAIL b2b_n2_data_in_w got=%h exp=1", data_in_w); end
    next_cycle(); @(negedge clk);
    checks++; if (wen_w !== 1'b1)     begin failures++; $display("FAIL b2b_n3_wen_w got=%b exp=1", wen_w); end
    checks++; if (data_in_w !== 3'h2) begin failures++; $display("FAIL b2b_n3_data_in_w got=%h exp=2", data_in_w); end
    checks++; if (data_rd !== 3'h2)   begin failures++; $display("FAIL b2b_n3_data_rd got=%h exp=2", data_rd); end
    // different threads in M and W: each reader sees only its own
    next_cycle();
    wen_e = 1; thr_e = 4'b0001; data_e = 3'h3; thr_rd = 4'b0001;
    next_cycle(); thr_e = 4'b1000; data_e = 3'h5;
    next_cycle(); idle_inputs(); @(negedge clk);
    checks++; if (data_rd !== 3'h3) begin failures++; $display("FAIL diffthr_w_data_rd got=%h exp=3", data_rd); end
    thr_rd = 4'b1000; #1;
    checks++; if (data_rd !== 3'h5) begin failures++; $display("FAIL diffthr_m_data_rd got=%h exp=5", data_rd); end
    thr_rd = 4'b0000; #1;
    checks++; if (byp_hit !== 1'b0 || data_rd !== 3'h7) begin
      failures++; $display("FAIL thr_rd_zero byp=%b data_rd=%h exp byp=0 data_rd=7", byp_hit, data_rd); end
  endtask

  task automatic test_bad_thread();
    thr_rd = 4'b0011; data_rf = 3'h0;
    next_cycle();
    wen_e = 1; thr_e = 4'b0011; data_e = 3'h7;
    next_cycle(); thr_e = 4'b0000; @(negedge clk);
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL multihot_n1_byp got=%b exp=0", byp_hit); end
    next_cycle(); idle_inputs(); @(negedge clk);
    checks++; if (wen_w !== 1'b0 || byp_hit !== 1'b0) begin
      failures++; $display("FAIL multihot_n2 wen_w=%b byp=%b exp 0 0", wen_w, byp_hit); end
    next_cycle(); @(negedge clk);
    checks++; if (wen_w !== 1'b0) begin failures++; $display("FAIL zerohot_n3_wen_w got=%b exp=0", wen_w); end
  endtask

  task automatic test_reset_mid_op();
    next_cycle();
    wen_e = 1; thr_e = 4'b0100; data_e = 3'h6; thr_rd = 4'b0100; data_rf = 3'h2;
    next_cycle(); idle_inputs(); reset = 1;
    next_cycle(); reset = 0; @(negedge clk);
    checks++; if (wen_w !== 1'b0)     begin failures++; $display("FAIL midreset_wen_w got=%b exp=0", wen_w); end
    checks++; if (byp_hit !== 1'b0)   begin failures++; $display("FAIL midreset_byp got=%b exp=0", byp_hit); end
    checks++; if (data_in_w !== 3'h0) begin failures++; $display("FAIL midreset_data_in_w got=%h exp=0", data_in_w); end
    checks++; if (data_rd !== 3'h2)   begin failures++; $display("FAIL midreset_data_rd got=%h exp=2", data_rd); end
  endtask

`ifdef EXU_REGW_PAR_EN
  task automatic test_parity();
    next_cycle();
    wen_e = 1; thr_e = 4'b0001; data_e = 3'h3;
    next_cycle(); idle_inputs();
    next_cycle(); @(negedge clk);
    checks++; if (wen_w !== 1'b1 || par_err_w !== 1'b0) begin
      failures++; $display("FAIL par_clean wen_w=%b par_err_w=%b exp 1 0", wen_w, par_err_w); end
    next_cycle();
    wen_e = 1; thr_e = 4'b0001; data_e = 3'h3;
    next_cycle(); idle_inputs();
    next_cycle(); force dut.data_w = 3'h2; @(negedge clk);
    checks++; if (wen_w !== 1'b1 || par_err_w !== 1'b1) begin
      failures++; $display("FAIL par_flip wen_w=%b par_err_w=%b exp 1 1", wen_w, par_err_w); end
    release dut.data_w;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_kill();
    test_back_to_back();
    test_bad_thread();
    test_reset_mid_op();
`ifdef EXU_REGW_PAR_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
